// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: owns the cipher state, walks one round per clock
// through an external round datapath and applies AddRoundKey per byte lane.

module aes_ark_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel_blk,
  input  logic [VEC_W-1:0] blk,
  input  logic [VEC_W-1:0] res,
  input  logic [VEC_W-1:0] rk,
  output logic [VEC_W-1:0] q
);
  assign q = (sel_blk ? blk : res) ^ rk;
endmodule

module aes_round_sequencer #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [127:0]   i_block,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [127:0]   o_block,
  input  logic           i_abort,
  input  logic           i_key_rdy,
  output logic [RKW-1:0] o_rk_idx,
  input  logic [127:0]   i_rk,
  output logic [127:0]   o_rd_state,
  output logic           o_rd_final,
  input  logic [127:0]   i_rd_result
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam logic [RKW-1:0] NR_I = RKW'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;

  st_e                              st;
  logic [RKW-1:0]                   rnd;
  logic [RKW-1:0]                   rnd_nxt;
  logic [127:0]                     state_q;
  logic                             accept;
  logic                             sel_blk;
  logic [NUM_LANES-1:0][VEC_W-1:0]  blk_l, res_l, rk_l, ark_l;

  assign blk_l = i_block;
  assign res_l = i_rd_result;
  assign rk_l  = i_rk;
  // Key 0 whitens the incoming block in IDLE; later rounds key the datapath result.
  assign sel_blk = (st == IDLE);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_ark_lane #(.VEC_W(VEC_W)) u_ark (
      .sel_blk (sel_blk),
      .blk     (blk_l[l]),
      .res     (res_l[l]),
      .rk      (rk_l[l]),
      .q       (ark_l[l])
    );
  end

  assign o_ready    = (st == IDLE) && i_key_rdy;
  // Abort takes priority over a new block even while idle.
  assign accept     = o_ready && i_valid && !i_abort;
  assign rnd_nxt    = rnd + 1'b1;
  assign o_rk_idx   = rnd;
  assign o_rd_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st         <= IDLE;
      rnd        <= '0;
      state_q    <= '0;
      o_block    <= '0;
      o_valid    <= 1'b0;
      o_rd_final <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (accept) begin
            state_q    <= ark_l;
            rnd        <= RKW'(1);
            o_rd_final <= (NR_I == RKW'(1));
            st         <= ROUND;
          end
        end
        ROUND: begin
          if (i_abort) begin
            rnd        <= '0;
            o_rd_final <= 1'b0;
            st         <= IDLE;
          end else begin
            state_q <= ark_l;
            if (rnd == NR_I) begin
              // rnd parks at 0 so o_rk_idx never leaves the valid key range.
              o_block    <= ark_l;
              o_valid    <= 1'b1;
              rnd        <= '0;
              o_rd_final <= 1'b0;
              st         <= DONE;
            end else begin
              rnd        <= rnd_nxt;
              o_rd_final <= (rnd_nxt == NR_I);
            end
          end
        end
        DONE: begin
          if (i_abort || i_ready) begin
            o_valid <= 1'b0;
            st      <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: ideal AES round datapath + AES-128 key schedule around the sequencer,
// checked against FIPS-197 / SP800-38A known answers.

module tb_aes_round_sequencer;
  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_block;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_block;
  logic         i_abort;
  logic         i_key_rdy;
  logic [3:0]   o_rk_idx;
  logic [127:0] i_rk;
  logic [127:0] o_rd_state;
  logic         o_rd_final;
  logic [127:0] i_rd_result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0][127:0] rks;

  aes_round_sequencer #(.NR(10), .RKW(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_block(i_block), .o_valid(o_valid), .i_ready(i_ready), .o_block(o_block),
    .i_abort(i_abort), .i_key_rdy(i_key_rdy), .o_rk_idx(o_rk_idx), .i_rk(i_rk),
    .o_rd_state(o_rd_state), .o_rd_final(o_rd_final), .i_rd_result(i_rd_result)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01; p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  assign i_rd_result = aes_round(o_rd_state, o_rd_final);
  assign i_rk        = (o_rk_idx <= 4'd10) ? rks[o_rk_idx] : 128'h0;

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wait_idx(input logic [3:0] k, output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_rk_idx == k) begin to = 1'b0; break; end
      cyc();
    end
  endtask

  task automatic wait_valid(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_valid) begin to = 1'b0; break; end
      cyc();
    end
  endtask

  // Called at a negedge with the controller idle; leaves it idle again.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output bit to);
    set_key(key);
    i_block = pt; i_valid = 1'b1; i_ready = 1'b1;
    cyc();
    i_valid = 1'b0;
    wait_valid(to);
    ct = o_block;
    cyc();
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  vec_t         vt [4];
  logic [127:0] ct;
  bit           to;
  logic [127:0] b2b_exp [3];
  logic [127:0] b2b_pt  [3];
  int           out_cyc [3];

  initial begin
    vt[0] = '{K1, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vt[1] = '{K2, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[2] = '{K1, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vt[3] = '{K1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_abort = 1'b0;
    i_key_rdy = 1'b0; i_block = '0;
    set_key(K1);

    // Reset values
    #2;
    chk("rst_valid", 128'(o_valid), 128'h0);
    chk("rst_block", o_block, 128'h0);
    chk("rst_idx", 128'(o_rk_idx), 128'h0);
    chk("rst_final", 128'(o_rd_final), 128'h0);
    chk("rst_state", o_rd_state, 128'h0);
    chk("rst_ready", 128'(o_ready), 128'h0);
    cyc(); cyc();
    i_rst_n = 1'b1;

    // Key not ready: i_valid is ignored
    i_valid = 1'b1; i_block = vt[0].pt;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("keyrdy_ready", 128'(o_ready), 128'h0);
      chk("keyrdy_idx", 128'(o_rk_idx), 128'h0);
      chk("keyrdy_state", o_rd_state, 128'h0);
    end
    i_key_rdy = 1'b1;
    #1 chk("keyrdy_rise", 128'(o_ready), 128'h1);

    // FIPS-197 App.B with per-round checks
    cyc();
    i_valid = 1'b0;
    chk("b_idx1", 128'(o_rk_idx), 128'h1);
    chk("b_state0", o_rd_state, vt[0].pt ^ K1);
    chk("b_final1", 128'(o_rd_final), 128'h0);
    chk("b_ready_busy", 128'(o_ready), 128'h0);
    for (int j = 2; j <= 10; j++) begin
      cyc();
      chk($sformatf("b_idx%0d", j), 128'(o_rk_idx), 128'(j));
      chk($sformatf("b_final%0d", j), 128'(o_rd_final), 128'(j == 10));
      chk($sformatf("b_valid%0d", j), 128'(o_valid), 128'h0);
    end
    cyc();
    chk("b_valid", 128'(o_valid), 128'h1);
    chk("b_block", o_block, vt[0].ct);
    chk("b_ready_done", 128'(o_ready), 128'h0);

    // Backpressure hold in DONE
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", 128'(o_valid), 128'h1);
      chk("bp_block", o_block, vt[0].ct);
      chk("bp_ready", 128'(o_ready), 128'h0);
    end
    i_ready = 1'b1;
    cyc();
    chk("bp_drop", 128'(o_valid), 128'h0);
    chk("bp_ready_back", 128'(o_ready), 128'h1);
    chk("bp_block_kept", o_block, vt[0].ct);

    // Known-answer table
    for (int i = 0; i < 4; i++) begin
      run_block(vt[i].key, vt[i].pt, ct, to);
      chk($sformatf("tbl%0d_timeout", i), 128'(to), 128'h0);
      chk($sformatf("tbl%0d_ct", i), ct, vt[i].ct);
    end

    // Abort at round 5, no output, then FIPS C.1
    set_key(K1);
    i_block = vt[0].pt; i_valid = 1'b1;
    cyc();
    i_valid = 1'b0;
    wait_idx(4'd5, to);
    chk("ab_wait", 128'(to), 128'h0);
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("ab_idx", 128'(o_rk_idx), 128'h0);
    chk("ab_valid", 128'(o_valid), 128'h0);
    chk("ab_ready", 128'(o_ready), 128'h1);
    chk("ab_final", 128'(o_rd_final), 128'h0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        cyc();
        if (o_valid) seen = 1'b1;
      end
      chk("ab_no_output", 128'(seen), 128'h0);
    end
    chk("ab_block_kept", o_block, vt[3].ct);
    run_block(vt[1].key, vt[1].pt, ct, to);
    chk("ab_c1_timeout", 128'(to), 128'h0);
    chk("ab_c1_ct", ct, vt[1].ct);

    // Abort beats i_valid in IDLE
    i_abort = 1'b1; i_valid = 1'b1; i_block = vt[0].pt;
    set_key(K1);
    cyc();
    chk("ab_idle_idx", 128'(o_rk_idx), 128'h0);
    chk("ab_idle_state", o_rd_state, vt[1].ct);
    i_abort = 1'b0; i_valid = 1'b0;

    // Abort together with i_ready in DONE discards the result
    i_ready = 1'b0; i_valid = 1'b1;
    cyc();
    i_valid = 1'b0;
    wait_valid(to);
    chk("abd_wait", 128'(to), 128'h0);
    chk("abd_block", o_block, vt[0].ct);
    i_abort = 1'b1; i_ready = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("abd_valid", 128'(o_valid), 128'h0);
    chk("abd_block_kept", o_block, vt[0].ct);
    chk("abd_ready", 128'(o_ready), 128'h1);

    // Async reset at round 3
    i_valid = 1'b1;
    cyc();
    i_valid = 1'b0;
    wait_idx(4'd3, to);
    chk("rr_wait", 128'(to), 128'h0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rr_valid", 128'(o_valid), 128'h0);
    chk("rr_block", o_block, 128'h0);
    chk("rr_idx", 128'(o_rk_idx), 128'h0);
    chk("rr_state", o_rd_state, 128'h0);
    chk("rr_final", 128'(o_rd_final), 128'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_block(vt[1].key, vt[1].pt, ct, to);
    chk("rr_restart_timeout", 128'(to), 128'h0);
    chk("rr_restart_ct", ct, vt[1].ct);

    // Back-to-back with i_valid held and i_ready tied high
    b2b_pt[0] = vt[0].pt; b2b_pt[1] = vt[2].pt; b2b_pt[2] = vt[3].pt;
    b2b_exp[0] = vt[0].ct; b2b_exp[1] = vt[2].ct; b2b_exp[2] = vt[3].ct;
    set_key(K1);
    i_ready = 1'b1; i_valid = 1'b1; i_block = b2b_pt[0];
    begin
      int nacc, nout;
      logic [3:0] prev_idx;
      nacc = 0; nout = 0; prev_idx = o_rk_idx;
      for (int c = 1; c <= 60 && nout < 3; c++) begin
        cyc();
        if (o_rk_idx == 4'd1 && prev_idx == 4'd0) begin
          nacc++;
          if (nacc < 3) i_block = b2b_pt[nacc];
          else i_valid = 1'b0;
        end
        prev_idx = o_rk_idx;
        if (o_valid) begin
          chk($sformatf("b2b_ct%0d", nout), o_block, b2b_exp[nout]);
          out_cyc[nout] = c;
          nout++;
        end
      end
      i_valid = 1'b0;
      chk("b2b_count", 128'(nout), 128'h3);
      if (nout == 3) begin
        chk("b2b_gap01", 128'(out_cyc[1] - out_cyc[0]), 128'd12);
        chk("b2b_gap12", 128'(out_cyc[2] - out_cyc[1]), 128'd12);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end
endmodule
